// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU bus: fixed-latency read/write completion
// backed by a flop-based word array with an independent preload port.
module mem_bus_responder #(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int         IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_read,
    input  logic             cpu_write,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic [3:0]       cpu_sel,
    output logic [31:0]      data_in_BUS,
    output logic             bus_full,
    output logic             bus_busy,
    output logic             bus_err,
    input  logic             pre_en,
    input  logic [IDX_W-1:0] pre_addr,
    input  logic [31:0]      pre_data
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] data_q, data_d;
    logic        full_q, full_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    // With LATENCY=1 the ACK-entry edge is the acceptance edge, so the
    // operation is taken straight from the bus instead of the latches.
    logic             op_rd, op_wr;
    logic [31:0]      op_addr, op_wdata;
    logic [3:0]       op_sel;
    logic [31:0]      off;
    logic [29:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             fault;
    logic             enter_ack;
    logic             commit;

    assign op_rd    = (state_q == IDLE) ? cpu_read  : rd_q;
    assign op_wr    = (state_q == IDLE) ? cpu_write : wr_q;
    assign op_addr  = (state_q == IDLE) ? cpu_addr  : addr_q;
    assign op_wdata = (state_q == IDLE) ? cpu_wdata : wdata_q;
    assign op_sel   = (state_q == IDLE) ? cpu_sel   : sel_q;

    assign off      = op_addr - BASE_ADDR;
    assign word_off = off[31:2];
    assign idx      = off[IDX_W+1:2];
    assign fault    = (off[1:0] != 2'b00) || (word_off >= 30'(DEPTH)) || (op_rd && op_wr);

    assign enter_ack = ((state_q == IDLE) && (cpu_read || cpu_write) && (LATENCY == 1))
                    || ((state_q == WAIT) && (cnt_q == 4'd1));
    assign commit    = enter_ack && op_wr && !fault;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        data_d  = data_q;
        full_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    rd_d    = cpu_read;
                    wr_d    = cpu_write;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    sel_d   = cpu_sel;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ACK : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_ack) begin
            full_d = 1'b1;
            err_d  = fault;
            if (op_rd) begin
                data_d = fault ? 32'h0 : mem_q[idx];
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            full_q  <= full_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Bus commit is scheduled after the preload so it wins on a shared word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is deliberately reset; contents must read back as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (pre_en) begin
                mem_q[pre_addr] <= pre_data;
            end
            if (commit) begin
                for (int b = 0; b < 4; b++) begin
                    if (op_sel[b]) begin
                        mem_q[idx][8*b +: 8] <= op_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign data_in_BUS = data_q;
    assign bus_full    = full_q;
    assign bus_busy    = busy_q;
    assign bus_err     = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: randomized traffic against a
// word-array reference model, plus directed latency, fault and reset cases.
module tb_mem_bus_responder;

    localparam int          LAT     = 2;
    localparam int          DEPTH   = 256;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          B_DEPTH = 16;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_sel;
    logic [31:0] data_in_bus;
    logic        bus_full, bus_busy, bus_err;
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    logic        b_read, b_write;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_sel;
    logic [31:0] b_data;
    logic        b_full, b_busy, b_err;
    logic        b_pre_en;
    logic [3:0]  b_pre_addr;
    logic [31:0] b_pre_data;

    int          n_tests;
    int          n_fail;
    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_last;

    mem_bus_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel),
        .data_in_BUS(data_in_bus), .bus_full(bus_full), .bus_busy(bus_busy), .bus_err(bus_err),
        .pre_en(pre_en), .pre_addr(pre_addr), .pre_data(pre_data)
    );

    mem_bus_responder #(.DEPTH(B_DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_read(b_read), .cpu_write(b_write),
        .cpu_addr(b_addr), .cpu_wdata(b_wdata), .cpu_sel(b_sel),
        .data_in_BUS(b_data), .bus_full(b_full), .bus_busy(b_busy), .bus_err(b_err),
        .pre_en(b_pre_en), .pre_addr(b_pre_addr), .pre_data(b_pre_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference model: the outcome of a request from address arithmetic alone.
    task automatic model_issue(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] sel);
        logic [31:0] off;
        logic [31:0] word;
        logic        bad;
        exp_t        e;
        off  = addr - BASE;
        word = off / 4;
        bad  = (off % 4 != 0) || (word >= 32'(DEPTH)) || (rd && wr);
        if (rd) begin
            model_last = bad ? 32'h0 : model_mem[word];
        end
        if (wr && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) model_mem[word][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        e.data = model_last;
        e.err  = bad;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_last = '0;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = 8'(idx);
        pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
        model_mem[idx] = d;
    endtask

    // Issue one request for one cycle and time its completion.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel);
        int n;
        bit got;
        @(negedge clk);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_sel   = sel;
        model_issue(rd, wr, addr, wdata, sel);
        @(posedge clk);
        n   = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (n == 0) begin
                cpu_read  = 1'b0;
                cpu_write = 1'b0;
            end
            n++;
            if (bus_full) got = 1;
            else check("busy_in_wait", 32'(bus_busy), 32'd1);
        end
        check("latency", n, LAT);
        check("busy_in_ack", 32'(bus_busy), 32'd1);
        @(negedge clk);
        check("idle_after_ack", {30'd0, bus_full, bus_busy}, 32'd0);
    endtask

    task automatic b_txn(input string name, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel,
                         input logic pe, input logic [3:0] pa, input logic [31:0] pd,
                         input logic [31:0] exp_data);
        @(negedge clk);
        b_read     = rd;
        b_write    = wr;
        b_addr     = addr;
        b_wdata    = wdata;
        b_sel      = sel;
        b_pre_en   = pe;
        b_pre_addr = pa;
        b_pre_data = pd;
        @(posedge clk);
        @(negedge clk);
        b_read   = 1'b0;
        b_write  = 1'b0;
        b_pre_en = 1'b0;
        check({name, "_full"}, 32'(b_full), 32'd1);
        check({name, "_data"}, b_data, exp_data);
        check({name, "_err"}, 32'(b_err), 32'd0);
        @(negedge clk);
        check({name, "_done"}, {30'd0, b_full, b_busy}, 32'd0);
    endtask

    // Monitor: every completion on DUT A is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus_full) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_bus_full: got data %h with no request outstanding", data_in_bus);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", data_in_bus, e.data);
                    check("sb_err", 32'(bus_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        int          cnt;
        logic [31:0] addr;
        logic        rd, wr;
        n_tests = 0;
        n_fail  = 0;
        model_clear();
        rst = 1'b0;
        {cpu_read, cpu_write, pre_en, b_read, b_write, b_pre_en} = '0;
        cpu_addr = '0; cpu_wdata = '0; cpu_sel = '0; pre_addr = '0; pre_data = '0;
        b_addr = '0; b_wdata = '0; b_sel = '0; b_pre_addr = '0; b_pre_data = '0;
        repeat (3) @(negedge clk);
        check("rst_data", data_in_bus, 32'h0);
        check("rst_full", 32'(bus_full), 32'd0);
        check("rst_busy", 32'(bus_busy), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        rst = 1'b1;

        // Basic read with latency 2.
        preload(3, 32'h0000_0001);
        do_req(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
        check("read_word3", data_in_bus, 32'h0000_0001);

        // Partial write merges with preloaded word; write completion keeps read data.
        preload(1, 32'hFFFF_0000);
        do_req(1'b0, 1'b1, 32'h04, 32'h1234_5678, 4'b0011);
        check("write_keeps_data", data_in_bus, 32'h0000_0001);
        do_req(1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
        check("merged_word1", data_in_bus, 32'hFFFF_5678);

        // Misaligned and out-of-range faults.
        do_req(1'b1, 1'b0, 32'h0000_0402, 32'h0, 4'h0);
        do_req(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
        check("oob_read_zero", data_in_bus, 32'h0);
        do_req(1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 4'hF);
        do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0);

        // Read and write together fault; held read completes once per LAT+1 cycles.
        preload(2, 32'h0000_2222);
        do_req(1'b1, 1'b1, 32'h08, 32'hAAAA_AAAA, 4'hF);
        do_req(1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) model_issue(1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
        @(negedge clk);
        cpu_read = 1'b1;
        cpu_addr = 32'h08;
        cnt = 0;
        repeat (3 * (LAT + 1)) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_full) cnt++;
        end
        cpu_read = 1'b0;
        check("held_read_count", cnt, 3);
        @(negedge clk);
        check("held_read_idle", 32'(bus_busy), 32'd0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 7) == 0) preload($urandom_range(0, 15), $urandom);
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = 32'((DEPTH + $urandom_range(0, 7)) * 4);
                2:       addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                3:       addr = 32'($urandom_range(0, DEPTH - 1) * 4);
                default: addr = 32'($urandom_range(0, 15) * 4);
            endcase
            cnt = $urandom_range(0, 19);
            rd  = (cnt < 9) || (cnt == 19);
            wr  = (cnt >= 9);
            do_req(rd, wr, addr, $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a write aborts it and clears the array.
        preload(3, 32'h0000_0033);
        do_req(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
        @(negedge clk);
        cpu_write = 1'b1;
        cpu_addr  = 32'h10;
        cpu_wdata = 32'hDEAD_BEEF;
        cpu_sel   = 4'hF;
        @(posedge clk);
        #3;
        cpu_write = 1'b0;
        check("busy_before_reset", 32'(bus_busy), 32'd1);
        check("data_before_reset", data_in_bus, 32'h0000_0033);
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        check("abort_data", data_in_bus, 32'h0);
        check("abort_full", 32'(bus_full), 32'd0);
        check("abort_busy", 32'(bus_busy), 32'd0);
        check("abort_err", 32'(bus_err), 32'd0);
        repeat (2) @(negedge clk);
        check("abort_no_full", 32'(bus_full), 32'd0);
        rst = 1'b1;
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        check("aborted_write_absent", data_in_bus, 32'h0);
        do_req(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);

        // LATENCY=1 instance: same-edge preload/read, then preload vs bus write.
        b_txn("b_pre_same_edge", 1'b1, 1'b0, 32'h00, 32'h0, 4'h0, 1'b1, 4'd0, 32'hA5A5_A5A5, 32'h0);
        b_txn("b_read_lat1", 1'b1, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 32'hA5A5_A5A5);
        b_txn("b_collide_wr", 1'b0, 1'b1, 32'h04, 32'h1111_2222, 4'hF, 1'b1, 4'd1, 32'h9999_9999,
              32'hA5A5_A5A5);
        b_txn("b_collide_rd", 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 4'd0, 32'h0, 32'h1111_2222);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side end of the CPU memory bus: accepts a read or write request from cpu_core and returns data plus a one-cycle bus_full completion strobe after a fixed latency.
- Backed by a flop-based word array, with a preload port so benches can seed instructions and data without modelling bus timing by hand.
- Sits between cpu_core's address_out/data_out_BUS outputs and its data_in_BUS/bus_full inputs.

Parameters:
DEPTH, 256, number of 32-bit words in the array (power of two).
LATENCY, 2, clock edges from request acceptance to the bus_full cycle; legal range 1..15.
BASE_ADDR, 32'h0000_0000, byte address that maps to word 0.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous reset, active-low (rst=0 resets).
cpu_read  in  1  read request; level, sampled only in IDLE.
cpu_write  in  1  write request; level, sampled only in IDLE.
cpu_addr  in  32  byte address of the request.
cpu_wdata  in  32  write data.
cpu_sel  in  4  byte enables for writes (bit i enables byte i, [7:0] = byte 0).
data_in_BUS  out  32  read data returned to the CPU.
bus_full  out  1  one-cycle completion strobe.
bus_busy  out  1  high while a request is in flight (WAIT or ACK).
bus_err  out  1  high with bus_full when the completed request faulted.
pre_en  in  1  preload strobe.
pre_addr  in  $clog2(DEPTH)  preload word index.
pre_data  in  32  preload word.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; data_in_BUS, bus_full, bus_busy and bus_err are all 0; latch registers are 0; every array word is 0.
- FSM states: IDLE, WAIT, ACK.
- IDLE, on an edge with cpu_read|cpu_write=1:
  - latch op, cpu_addr, cpu_wdata and cpu_sel;
  - load cnt=LATENCY-1;
  - go to WAIT, or straight to ACK if LATENCY=1.
- WAIT: decrement cnt each edge; when cnt=1 at an edge, go to ACK. Result: bus_full is high in the cycle after the LATENCY-th edge counted from acceptance.
- ACK, lasting exactly one cycle:
  - bus_full=1;
  - data_in_BUS and bus_err are valid;
  - next edge returns to IDLE.
- bus_busy=1 in WAIT and ACK. Requests presented in WAIT or ACK are ignored and are not queued. Minimum request spacing is LATENCY+1 cycles.
- Address decode:
  - off = cpu_addr - BASE_ADDR (32-bit wrap);
  - index = off[31:2].
  - Fault if off[1:0]!=0, or index>=DEPTH, or cpu_read and cpu_write were both 1 at acceptance.
- Read:
  - data_in_BUS is updated with the array word on the edge entering ACK; faulted reads drive 32'h0.
  - data_in_BUS holds its value until the next read completes; writes do not change it.
- Write: bytes selected by cpu_sel are committed on the edge entering ACK; faulted writes commit nothing. cpu_sel=0 completes normally with no change.
- bus_err: set with bus_full in ACK, cleared on leaving ACK.
- Preload: pre_en writes pre_data to array[pre_addr] on any edge, in any state.
  - If it hits the same word as a write commit on the same edge, the bus write wins.
  - A read entering ACK on the same edge returns the pre-edge contents.
- Reset in WAIT or ACK aborts the request: no commit, no bus_full. Array contents return to 0.
- cnt width is 4 bits. The array is synchronous-write; reads sample at the ACK-entry edge, so there is no combinational path from cpu_addr to data_in_BUS.

Test Plan:
1. Preload word 3=32'h0000_0001, LATENCY=2; cpu_read addr 32'h0C for one cycle -> bus_full high exactly 2 edges after acceptance, data_in_BUS=1, bus_err=0, bus_busy high for 2 cycles.
2. Preload word 1=32'hFFFF_0000; write addr 32'h04, wdata 32'h1234_5678, sel=4'b0011; then read 32'h04 -> 32'hFFFF_5678, data_in_BUS unchanged by the write's ACK.
3. Read 32'h0000_0402 (misaligned) and read 32'h0000_0400 (index 256 = DEPTH) -> each gives bus_full with bus_err=1 and data_in_BUS=0; a write to 32'h400 leaves the array unchanged.
4. cpu_read and cpu_write both 1 at addr 32'h08 -> bus_err=1, word 2 unchanged. Holding cpu_read high through WAIT/ACK -> exactly one completion per LATENCY+1 cycles.
5. Write 32'hDEAD_BEEF, sel=4'hF to 32'h10; drive rst=0 mid-WAIT -> outputs 0 immediately with no bus_full; after release, read 32'h10 -> 0.
6. LATENCY=1 build: read 32'h00 after preload 32'hA5A5_A5A5 -> bus_full in the cycle after acceptance, data 32'hA5A5_A5A5. Preload and bus write to the same word on the same edge -> bus write value retained.
